// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle core's sequencing logic: next-PC modes,
// sequencer state, and the sizing helper for the fetch wait counter.
package cpu_pkg;

  localparam logic [2:0] MODE_SEQ  = 3'd0;
  localparam logic [2:0] MODE_BEQ  = 3'd1;
  localparam logic [2:0] MODE_BNE  = 3'd2;
  localparam logic [2:0] MODE_JIMM = 3'd3;
  localparam logic [2:0] MODE_JREG = 3'd4;
  localparam logic [2:0] MODE_HALT = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Counter must hold 0..wait_max inclusive; never narrower than one bit.
  function automatic int wait_cnt_w(input int wait_max);
    return (wait_max < 1) ? 1 : $clog2(wait_max + 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory port: one-cycle req pulse with address out, valid-qualified
// read data back after any latency; no backpressure towards the sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic [INST_W-1:0] rdata;

  modport master (output req, output addr, input valid, input rdata);
  modport slave  (input req, input addr, output valid, output rdata);
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection (0 cycles); all arithmetic wraps modulo 2^ADDR_W.
// No handshake: the result is only consumed when the sequencer commits.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int IMM_W  = 16,
  parameter int JIMM_W = 26
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [2:0]        mode,
  input  logic              zero,
  input  logic [IMM_W-1:0]  branch_off,
  input  logic [JIMM_W-1:0] jimm,
  input  logic [ADDR_W-1:0] jreg,
  output logic [ADDR_W-1:0] next_pc
);

  localparam int OFF_W = (IMM_W  > ADDR_W) ? IMM_W  : ADDR_W;
  localparam int JMP_W = (JIMM_W > ADDR_W) ? JIMM_W : ADDR_W;

  // One spare top bit keeps the discarded-bit slices non-empty for any widths.
  logic [OFF_W:0]    off_ext;
  logic [JMP_W:0]    jimm_ext;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] taken_pc;
  logic              unused_hi_bits;

  assign off_ext        = (OFF_W + 1)'($signed(branch_off));
  assign jimm_ext       = (JMP_W + 1)'(jimm);
  assign unused_hi_bits = ^{off_ext[OFF_W:ADDR_W], jimm_ext[JMP_W:ADDR_W]};

  assign seq_pc   = pc + ADDR_W'(1);
  assign taken_pc = seq_pc + off_ext[ADDR_W-1:0];

  always_comb begin
    next_pc = seq_pc;
    case (mode)
      MODE_BEQ:  next_pc = zero  ? taken_pc : seq_pc;
      MODE_BNE:  next_pc = !zero ? taken_pc : seq_pc;
      MODE_JIMM: next_pc = jimm_ext[ADDR_W-1:0];
      MODE_JREG: next_pc = jreg;
      default:   next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC owner and fetch sequencer: IDLE/FETCH/WAIT/EXEC/HALT, min 3 cycles per instruction,
// EXEC L+1 cycles after FETCH; memory stalls are absorbed in WAIT up to WAIT_MAX+1 cycles.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int          INST_W   = 32,
  parameter int          IMM_W    = 16,
  parameter int          JIMM_W   = 26,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int          WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              ready,
  input  logic [2:0]        mode,
  input  logic              zero,
  input  logic              commit,
  input  logic [IMM_W-1:0]  branch_off,
  input  logic [JIMM_W-1:0] jimm,
  input  logic [ADDR_W-1:0] jreg,
  pc_sequencer_if.master    imem,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              halted,
  output logic              fault
);

  localparam int               CNT_W   = wait_cnt_w(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  state_t            state, state_nxt;
  logic              ready_q;
  logic              ready_edge;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] next_pc;
  logic [INST_W-1:0] inst_nxt;
  logic              fault_nxt;

  next_pc_calc #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W),
    .JIMM_W (JIMM_W)
  ) u_next_pc (
    .pc         (pc),
    .mode       (mode),
    .zero       (zero),
    .branch_off (branch_off),
    .jimm       (jimm),
    .jreg       (jreg),
    .next_pc    (next_pc)
  );

  assign ready_edge = ready & ~ready_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b0;
      pc       <= RESET_PC;
      inst     <= '0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ready_q  <= ready;
      pc       <= pc_nxt;
      inst     <= inst_nxt;
      fault    <= fault_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    inst_nxt     = inst;
    fault_nxt    = fault;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (ready_edge) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        wait_cnt_nxt = '0;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        // A response on the final allowed cycle still beats the timeout.
        if (imem.valid) begin
          inst_nxt  = imem.rdata;
          state_nxt = ST_EXEC;
        end else if (wait_cnt == CNT_MAX) begin
          fault_nxt = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      ST_EXEC: begin
        if (commit) begin
          pc_nxt    = next_pc;
          state_nxt = (mode == MODE_HALT) ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (ready_edge && !fault) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign imem.req   = (state == ST_FETCH);
  assign imem.addr  = pc;
  assign inst_valid = (state == ST_EXEC);
  assign halted     = (state == ST_HALT);
  assign link       = pc + ADDR_W'(1);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: RESET_PC=0x0010, WAIT_MAX=3, memory responses
// driven by hand at chosen WAIT cycles; all inputs change on the falling edge.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        ready;
  logic [2:0]  mode;
  logic        zero;
  logic        commit;
  logic [15:0] branch_off;
  logic [25:0] jimm;
  logic [15:0] jreg;
  logic [15:0] pc;
  logic [15:0] link;
  logic [31:0] inst;
  logic        inst_valid;
  logic        halted;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int req_cyc = 0;
  int prev_req_cyc = 0;

  pc_sequencer_if #(.ADDR_W(16), .INST_W(32)) imem ();

  pc_sequencer #(
    .ADDR_W   (16),
    .INST_W   (32),
    .IMM_W    (16),
    .JIMM_W   (26),
    .RESET_PC (16'h0010),
    .WAIT_MAX (3)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .ready      (ready),
    .mode       (mode),
    .zero       (zero),
    .commit     (commit),
    .branch_off (branch_off),
    .jimm       (jimm),
    .jreg       (jreg),
    .imem       (imem),
    .pc         (pc),
    .link       (link),
    .inst       (inst),
    .inst_valid (inst_valid),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input logic [15:0] exp_addr);
    int n = 0;
    while (imem.req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 64'(imem.req), 64'd1);
    check({tag, "_addr"}, 64'(imem.addr), 64'(exp_addr));
    prev_req_cyc = req_cyc;
    req_cyc = cyc;
  endtask

  // Fetch at exp_addr, answer on WAIT cycle lat, then commit with the given controls.
  task automatic run_instr(input string tag, input logic [15:0] exp_addr, input int lat,
                           input logic [31:0] word, input logic [2:0] m, input logic z,
                           input logic [15:0] off, input logic [25:0] ji,
                           input logic [15:0] jr);
    wait_req(tag, exp_addr);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i == lat) begin
        imem.valid = 1'b1;
        imem.rdata = word;
      end
    end
    @(negedge clk);
    imem.valid = 1'b0;
    check({tag, "_ivld"}, 64'(inst_valid), 64'd1);
    check({tag, "_inst"}, 64'(inst), 64'(word));
    mode       = m;
    zero       = z;
    branch_off = off;
    jimm       = ji;
    jreg       = jr;
    commit     = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  initial begin
    n_reset    = 1'b0;
    ready      = 1'b0;
    mode       = MODE_SEQ;
    zero       = 1'b0;
    commit     = 1'b0;
    branch_off = '0;
    jimm       = '0;
    jreg       = '0;
    imem.valid = 1'b0;
    imem.rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", 64'(pc), 64'h0010);
    check("rst_addr", 64'(imem.addr), 64'h0010);
    check("rst_link", 64'(link), 64'h0011);
    check("rst_inst", 64'(inst), 64'h0);
    check("rst_ivld", 64'(inst_valid), 64'h0);
    check("rst_req", 64'(imem.req), 64'h0);
    check("rst_halted", 64'(halted), 64'h0);
    check("rst_fault", 64'(fault), 64'h0);

    n_reset = 1'b1;
    @(negedge clk);
    ready = 1'b1;

    // Sequential stream with a 1-cycle memory: requests 3 cycles apart.
    run_instr("seq0", 16'h0010, 1, 32'hA5A5_0001, MODE_SEQ, 1'b0, 16'h0, 26'h0, 16'h0);
    run_instr("seq1", 16'h0011, 1, 32'hA5A5_0002, MODE_JREG, 1'b0, 16'h0, 26'h0, 16'h0020);
    check("req_spacing", 64'(req_cyc - prev_req_cyc), 64'd3);

    run_instr("beq_t", 16'h0020, 2, 32'h0000_0101, MODE_BEQ, 1'b1, 16'hFFFC, 26'h0, 16'h0);
    run_instr("jr_a", 16'h001D, 1, 32'h0000_0102, MODE_JREG, 1'b0, 16'h0, 26'h0, 16'h0020);
    run_instr("beq_n", 16'h0020, 3, 32'h0000_0103, MODE_BEQ, 1'b0, 16'hFFFC, 26'h0, 16'h0);
    run_instr("jr_b", 16'h0021, 1, 32'h0000_0104, MODE_JREG, 1'b0, 16'h0, 26'h0, 16'h0020);
    run_instr("bne_t", 16'h0020, 1, 32'h0000_0105, MODE_BNE, 1'b0, 16'hFFFC, 26'h0, 16'h0);
    run_instr("jr_c", 16'h001D, 1, 32'h0000_0106, MODE_JREG, 1'b0, 16'h0, 26'h0, 16'h0020);
    run_instr("bne_n", 16'h0020, 1, 32'h0000_0107, MODE_BNE, 1'b1, 16'hFFFC, 26'h0, 16'h0);
    run_instr("jr_d", 16'h0021, 1, 32'h0000_0108, MODE_JREG, 1'b0, 16'h0, 26'h0, 16'hFFFF);
    run_instr("wrap", 16'hFFFF, 1, 32'h0000_0109, MODE_SEQ, 1'b0, 16'h0, 26'h0, 16'h0);
    run_instr("jimm", 16'h0000, 1, 32'h0000_010A, MODE_JIMM, 1'b0, 16'h0, 26'h3ABCDEF, 16'h0);
    run_instr("jreg", 16'hCDEF, 1, 32'h0000_010B, MODE_JREG, 1'b0, 16'h0, 26'h0, 16'h1234);
    run_instr("mode7", 16'h1234, 1, 32'h0000_010C, 3'd7, 1'b1, 16'h0008, 26'h0, 16'h0);
    run_instr("jr_e", 16'h1235, 1, 32'h0000_010D, MODE_JREG, 1'b0, 16'h0, 26'h0, 16'h0040);

    // Halt at 0x0040; response on the last allowed WAIT cycle must not fault.
    run_instr("halt", 16'h0040, 4, 32'hCAFE_0040, MODE_HALT, 1'b0, 16'h0, 26'h0, 16'h0);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_pc", 64'(pc), 64'h0041);
    check("halt_link", 64'(link), 64'h0042);
    check("halt_fault", 64'(fault), 64'd0);
    repeat (3) @(negedge clk);
    check("halt_hold_halted", 64'(halted), 64'd1);
    check("halt_hold_req", 64'(imem.req), 64'd0);

    ready = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    run_instr("resume", 16'h0041, 2, 32'hBEEF_0041, MODE_SEQ, 1'b0, 16'h0, 26'h0, 16'h0);

    // Fetch of 0x0042 never answered: fault after exactly 4 WAIT cycles.
    wait_req("tmo", 16'h0042);
    repeat (4) @(negedge clk);
    check("tmo_pre_fault", 64'(fault), 64'd0);
    check("tmo_pre_halted", 64'(halted), 64'd0);
    @(negedge clk);
    check("tmo_fault", 64'(fault), 64'd1);
    check("tmo_halted", 64'(halted), 64'd1);
    ready = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    check("tmo_blocked_req", 64'(imem.req), 64'd0);
    check("tmo_blocked_halted", 64'(halted), 64'd1);

    n_reset = 1'b0;
    ready   = 1'b0;
    @(negedge clk);
    check("clr_fault", 64'(fault), 64'd0);
    check("clr_halted", 64'(halted), 64'd0);
    check("clr_pc", 64'(pc), 64'h0010);
    check("clr_inst", 64'(inst), 64'h0);
    n_reset = 1'b1;
    @(negedge clk);
    ready = 1'b1;

    // Reset during WAIT of a 5-cycle fetch; the late response must be dropped.
    wait_req("late", 16'h0010);
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b0;
    ready   = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    check("late_idle_req", 64'(imem.req), 64'd0);
    @(negedge clk);
    @(negedge clk);
    imem.valid = 1'b1;
    imem.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem.valid = 1'b0;
    check("late_inst", 64'(inst), 64'h0);
    check("late_ivld", 64'(inst_valid), 64'd0);
    check("late_req", 64'(imem.req), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised instruction-sequencing unit for the multi-cycle core: owns the program counter, issues instruction-memory requests with a req/valid handshake, captures the fetched word, and computes the next PC from a control-supplied mode (sequential, conditional branch, jump-immediate, jump-register, halt). It succeeds the fixed-width PC register and PC multiplexer of the single-cycle CPU. It adds variable memory latency, start/resume on a `ready` edge, a fetch timeout fault, and configurable address/instruction widths.

## Interface
- ADDR_W, 16, PC / instruction-address width
- INST_W, 32, instruction word width
- IMM_W, 16, branch offset width (two's complement, in words)
- JIMM_W, 26, jump-immediate field width
- RESET_PC, 0, PC value after reset
- WAIT_MAX, 15, max cycles in WAIT before fault (≥1)

- clk  in  1  clock; all state changes on rising edge
- n_reset  in  1  reset, synchronous, active-low
- ready  in  1  start/resume request; rising edge acts
- mode  in  3  next-PC mode, sampled on commit
- zero  in  1  ALU zero flag, sampled on commit
- commit  in  1  control unit: current instruction finished
- branch_off  in  IMM_W  signed word offset
- jimm  in  JIMM_W  jump-immediate field
- jreg  in  ADDR_W  jump-register target
- imem_req  out  1  fetch request, one-cycle pulse
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_valid  in  1  fetch data valid
- imem_rdata  in  INST_W  fetched word
- pc  out  ADDR_W  current PC
- link  out  ADDR_W  pc+1 (return address)
- inst  out  INST_W  captured instruction
- inst_valid  out  1  inst holds current instruction; control may execute
- halted  out  1  in HALT state
- fault  out  1  sticky fetch timeout

## Operation
- States: IDLE, FETCH, WAIT, EXEC, HALT. Reset → IDLE.
- ready edge: ready_q register; edge = ready & ~ready_q. ready_q resets to 0.
- IDLE: on edge → FETCH.
- FETCH: imem_req=1 for exactly this cycle, imem_addr=pc; clear wait counter; → WAIT.
- WAIT: imem_valid=1 → inst<=imem_rdata, → EXEC. Otherwise increment counter; when the counter already equals WAIT_MAX and valid is still low → HALT, fault<=1. imem_valid in any other state is ignored.
- EXEC: inst_valid=1. On commit:
  - pc <= next_pc.
  - → HALT if mode=HALT, else → FETCH.
  - commit outside EXEC is ignored.
- HALT: halted=1. On edge with fault=0 → FETCH. fault=1 blocks resume until reset.
- Modes:
  - 0 SEQ: pc+1.
  - 1 BEQ: pc+1+sext(branch_off) if zero, else pc+1.
  - 2 BNE: the same taken target when !zero, else pc+1.
  - 3 JIMM: jimm[ADDR_W-1:0], zero-extended if JIMM_W<ADDR_W.
  - 4 JREG: jreg.
  - 5 HALT: pc+1, so a resume continues after the halt instruction.
  - 6, 7: treated as SEQ.
- Arithmetic is modulo 2^ADDR_W: pc=all-ones + 1 wraps to 0, and negative offsets wrap below 0.
- Reset mid-operation (any state): synchronous return to reset values. A pending memory response after reset is ignored because the unit is in IDLE.

## Timing
- Reset values:
  - State and PC: state IDLE, pc=RESET_PC, imem_addr=RESET_PC, link=RESET_PC+1.
  - Outputs: inst=0, inst_valid=0, imem_req=0, halted=0, fault=0.
  - Internal: wait counter 0.
- imem_req, inst_valid and halted decode from registered state only; there is no combinational input→output path. link is combinational from pc.
- Fetch latency with a 1-cycle memory:
  - Cycle t: FETCH, req.
  - t+1: WAIT, valid.
  - t+2: EXEC.
  - Commit at t+2 gives FETCH at t+3 with the new pc, so the minimum is 3 cycles per instruction.
- Memory latency L≥1: EXEC begins L+1 cycles after FETCH.
- Timeout: fault and HALT are entered at the end of the (WAIT_MAX+1)th WAIT cycle with no valid. Valid arriving on that same cycle wins and no fault is raised.
- Edge from IDLE/HALT gives FETCH on the next cycle. Holding ready high does not retrigger.

## Structure
- Shared package `cpu_pkg`:
  - mode encodings MODE_SEQ..MODE_HALT
  - state encoding
  - WAIT counter width function (clog2)
- Sub-module `next_pc_calc`: combinational, taking pc, mode, zero, branch_off, jimm, jreg and producing next_pc. Parametrised by ADDR_W, IMM_W, JIMM_W.

## Test plan
- Reset with RESET_PC=0x0010, then ready edge, 1-cycle memory, commit SEQ → imem_addr sequence 0x0010, 0x0011; req pulses 3 cycles apart.
- At pc=0x0020, mode BEQ, zero=1, branch_off=-4 → next fetch 0x001D; with zero=0 → 0x0021; BNE mirrors this.
- pc=0xFFFF with SEQ → 0x0000. JIMM with jimm=0x3ABCDEF → 0xCDEF. JREG with jreg=0x1234 → 0x1234.
- HALT mode at pc=0x0040: halted=1, pc=0x0041, and ready held high does not resume. A new ready edge → fetch 0x0041.
- WAIT_MAX=3, imem_valid never asserted → fault=1 and halted=1 after 4 WAIT cycles; a ready edge is ignored; n_reset=0 clears everything.
- Memory latency 5 cycles with n_reset=0 asserted during WAIT → IDLE next cycle and the late imem_valid is ignored (inst stays 0).
